// File: rtl/cache_pkg.sv
// Shared widths, address-field positions and controller state encoding for the
// direct-mapped read cache (3-bit tag, 10-bit index, 2-bit word offset).
package cache_pkg;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;
    localparam int TAG_W           = 3;
    localparam int INDEX_W         = 10;
    localparam int OFFSET_W        = 2;
    localparam int ADDR_W          = TAG_W + INDEX_W + OFFSET_W;

    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_W;
    localparam int TAG_LSB    = OFFSET_W + INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_WAIT,
        FILL,
        RESPOND
    } state_t;

    function automatic logic [ADDR_W-1:0] block_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:INDEX_LSB], {OFFSET_W{1'b0}}};
    endfunction

    // Word k of a block lives at bits [32k+31:32k].
    function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFFSET_W-1:0] off);
        return blk[off*WORD_W +: WORD_W];
    endfunction
endpackage

// File: rtl/cache_sat_counter.sv
// Performance counter that sticks at its maximum value instead of wrapping.
module cache_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= sat_inc(count);
    end
endmodule

// File: rtl/cache_read_controller.sv
// Read sequencer between the CPU port, the direct-mapped cache array and main
// memory: lookup, refill on miss, and saturating access/hit statistics.
module cache_read_controller
    import cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_rd_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               cpu_busy,
    output logic               cpu_ready,
    output logic [WORD_W-1:0]  cpu_data,
    output logic [ADDR_W-1:0]  cache_addr,
    output logic               cache_read,
    output logic               cache_en,
    output logic [BLOCK_W-1:0] cache_data_in,
    input  logic [WORD_W-1:0]  cache_data_out,
    input  logic               cache_hit,
    output logic               mem_rd_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [BLOCK_W-1:0] mem_data,
    output logic [CNT_W-1:0]   access_count,
    output logic [CNT_W-1:0]   hit_count
);
    state_t state;
    logic   acc_inc;
    logic   hit_inc;

    // cache_addr doubles as the latched request address; offsets are always
    // taken from it so a changing cpu_addr cannot disturb an in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cpu_busy      <= 1'b0;
            cpu_ready     <= 1'b0;
            cpu_data      <= '0;
            cache_addr    <= '0;
            cache_read    <= 1'b1;
            cache_en      <= 1'b0;
            cache_data_in <= '0;
            mem_rd_req    <= 1'b0;
            mem_addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_rd_req) begin
                        cache_addr <= cpu_addr;
                        cpu_busy   <= 1'b1;
                        cache_en   <= 1'b1;
                        cache_read <= 1'b1;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    cache_en <= 1'b0;
                    state    <= CHECK;
                end
                CHECK: begin
                    if (cache_hit) begin
                        cpu_data  <= cache_data_out;
                        cpu_ready <= 1'b1;
                        state     <= RESPOND;
                    end else begin
                        mem_rd_req <= 1'b1;
                        mem_addr   <= block_addr(cache_addr);
                        state      <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_rd_req    <= 1'b0;
                        cache_data_in <= mem_data;
                        cpu_data      <= word_sel(mem_data, cache_addr[OFFSET_W-1:OFFSET_LSB]);
                        cache_en      <= 1'b1;
                        cache_read    <= 1'b0;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    cache_en   <= 1'b0;
                    cache_read <= 1'b1;
                    cpu_ready  <= 1'b1;
                    state      <= RESPOND;
                end
                RESPOND: begin
                    cpu_ready <= 1'b0;
                    cpu_busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every CHECK cycle is one lookup; a hit seen there is one hit.
    assign acc_inc = (state == CHECK);
    assign hit_inc = (state == CHECK) && cache_hit;

    cache_sat_counter #(.CNT_W(CNT_W)) u_access_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (acc_inc),
        .count (access_count)
    );

    cache_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );
endmodule
